// File: rtl/cnn_pkg.sv
// Shared constants and sizing helpers for the sequential convolution engines.
// Holds the FSM state codes, accumulator sizing and the weight/bias address map.
package cnn_pkg;

    localparam logic [1:0] S_LOAD = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_ACT  = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    // Wide enough for K full-precision products plus a shifted bias without overflow.
    function automatic int acc_width(input int width, input int k);
        return 2 * width + $clog2(k) + 1;
    endfunction

    function automatic int waddr_bias_base(input int n2, input int k);
        return n2 * k;
    endfunction

    function automatic int waddr_width(input int n2, input int k);
        return $clog2(n2 * k + n2);
    endfunction

    function automatic int ch_width(input int n2);
        return (n2 > 1) ? $clog2(n2) : 1;
    endfunction

endpackage

// File: rtl/conv_layer_seq_if.sv
// Sample stream, result stream and register-file write port of conv_layer_seq.
// The master side is the window producer / consumer / configuration host.
interface conv_layer_seq_if
    import cnn_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N2    = 4,
    parameter int K     = 27
) ();

    localparam int AW = waddr_width(N2, K);
    localparam int CW = ch_width(N2);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    out_ch;
    logic             out_last;
    logic             w_we;
    logic [AW-1:0]    w_addr;
    logic [WIDTH-1:0] w_data;

    modport master (
        output in_valid, in_data, out_ready, w_we, w_addr, w_data,
        input  in_ready, out_valid, out_data, out_ch, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready, w_we, w_addr, w_data,
        output in_ready, out_valid, out_data, out_ch, out_last
    );

endinterface

// File: rtl/cnn_act_sat.sv
// Combinational activation: rescale accumulator, clip or wrap to WIDTH, then ReLU
// with an optional integer upper clamp.
module cnn_act_sat #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int ACC_W = 37
) (
    input  logic signed [ACC_W-1:0] acc,
    input  logic                    clip,
    input  logic                    relu,
    input  logic [7:0]              relu_c,
    output logic signed [WIDTH-1:0] y
);

    localparam int LW = ((WIDTH > 8 + FRAC) ? WIDTH : 8 + FRAC) + 1;
    localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    function automatic logic signed [WIDTH-1:0] sat_w(input logic signed [ACC_W-1:0] v);
        if (v > MAXV)
            return MAXV[WIDTH-1:0];
        else if (v < MINV)
            return MINV[WIDTH-1:0];
        else
            return v[WIDTH-1:0];
    endfunction

    logic signed [ACC_W-1:0] shifted;
    logic signed [WIDTH-1:0] r;
    logic signed [LW-1:0]    r_ext;
    logic signed [LW-1:0]    lim;

    assign shifted = acc >>> FRAC;
    // Clamp limit is compared at a width where relu_c<<FRAC cannot overflow.
    assign lim     = $signed({{(LW-8){1'b0}}, relu_c}) <<< FRAC;

    always_comb begin
        r     = clip ? sat_w(shifted) : shifted[WIDTH-1:0];
        r_ext = {{(LW-WIDTH){r[WIDTH-1]}}, r};
        y     = r;
        if (relu) begin
            if (r < 0)
                y = '0;
            else if ((relu_c != 8'd0) && (r_ext > lim))
                y = lim[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/conv_layer_seq.sv
// Time-multiplexed conv layer: buffers one FN x FN x N1 window, then a single MAC
// produces all N2 output channels in turn, each handed off over valid/ready.
module conv_layer_seq
    import cnn_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int N1    = 3,
    parameter int N2    = 4,
    parameter int FN    = 3
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cfg_clip,
    input  logic              cfg_relu,
    input  logic [7:0]        cfg_relu_c,
    conv_layer_seq_if.slave   bus,
    output logic              busy,
    output logic              err
);

    localparam int K         = N1 * FN * FN;
    localparam int ACC_W     = acc_width(WIDTH, K);
    localparam int AW        = waddr_width(N2, K);
    localparam int CW        = ch_width(N2);
    localparam int IW        = (K > 1) ? $clog2(K) : 1;
    localparam int NREG      = N2 * K + N2;
    localparam int BIAS_BASE = waddr_bias_base(N2, K);

    logic [1:0]              state;
    logic [IW-1:0]           idx;
    logic [CW-1:0]           oc;
    logic signed [ACC_W-1:0] acc_p0;
    logic                    clip_q;
    logic                    relu_q;
    logic [7:0]              relu_c_q;
    logic signed [WIDTH-1:0] rf  [2**AW];
    logic signed [WIDTH-1:0] win [2**IW];
    logic signed [2*WIDTH-1:0] prod;
    logic signed [WIDTH-1:0] act_y;
    logic [AW-1:0]           w_idx;
    logic                    idx_last;
    logic                    oc_last;
    logic                    accept;
    logic                    rf_wr;

    function automatic logic signed [ACC_W-1:0] bias_to_acc(input logic signed [WIDTH-1:0] b);
        logic signed [ACC_W-1:0] e;
        e = {{(ACC_W-WIDTH){b[WIDTH-1]}}, b};
        return e <<< FRAC;
    endfunction

    function automatic logic [AW-1:0] bias_addr(input logic [CW-1:0] o);
        return AW'(BIAS_BASE) + AW'(o);
    endfunction

    assign idx_last     = (idx == IW'(K - 1));
    assign oc_last      = (oc == CW'(N2 - 1));
    assign bus.in_ready = (state == S_LOAD);
    assign accept       = bus.in_valid && (state == S_LOAD);
    assign busy         = (state != S_LOAD) || (idx != '0);
    assign rf_wr        = bus.w_we && !busy && (int'(bus.w_addr) < NREG);
    assign w_idx        = AW'(oc) * AW'(K) + AW'(idx);
    assign prod         = (2*WIDTH)'(win[idx]) * (2*WIDTH)'(rf[w_idx]);

    cnn_act_sat #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC),
        .ACC_W (ACC_W)
    ) u_act (
        .acc    (acc_p0),
        .clip   (clip_q),
        .relu   (relu_q),
        .relu_c (relu_c_q),
        .y      (act_y)
    );

    // Storage is deliberately left unreset; contents are defined only once written.
    always_ff @(posedge clk) begin
        if (rf_wr)
            rf[bus.w_addr] <= bus.w_data;
        if (accept)
            win[idx] <= bus.in_data;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= S_LOAD;
            idx           <= '0;
            oc            <= '0;
            acc_p0        <= '0;
            clip_q        <= 1'b0;
            relu_q        <= 1'b0;
            relu_c_q      <= 8'd0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_ch    <= '0;
            bus.out_last  <= 1'b0;
            err           <= 1'b0;
        end else begin
            if (bus.w_we && busy)
                err <= 1'b1;
            case (state)
                S_LOAD: begin
                    if (accept) begin
                        if (idx_last) begin
                            idx      <= '0;
                            oc       <= '0;
                            acc_p0   <= bias_to_acc(rf[bias_addr('0)]);
                            clip_q   <= cfg_clip;
                            relu_q   <= cfg_relu;
                            relu_c_q <= cfg_relu_c;
                            state    <= S_MAC;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                // MAC stage: one product per cycle over the buffered window
                S_MAC: begin
                    acc_p0 <= acc_p0 + {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};
                    if (idx_last) begin
                        idx   <= '0;
                        state <= S_ACT;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                // ACT stage: activation result registered onto the output stream
                S_ACT: begin
                    bus.out_data  <= act_y;
                    bus.out_ch    <= oc;
                    bus.out_last  <= oc_last;
                    bus.out_valid <= 1'b1;
                    state         <= S_OUT;
                end
                default: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        if (oc_last) begin
                            oc    <= '0;
                            state <= S_LOAD;
                        end else begin
                            oc     <= oc + CW'(1);
                            acc_p0 <= bias_to_acc(rf[bias_addr(oc + CW'(1))]);
                            state  <= S_MAC;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_layer_seq.sv
// Bench for conv_layer_seq: single-channel engine for arithmetic and control
// scenarios, four-channel engine for channel sequencing and output backpressure.
module tb_conv_layer_seq;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       clip1, relu1, busy1, err1;
    logic [7:0] rc1;
    logic       clip4, relu4, busy4, err4;
    logic [7:0] rc4;

    int n_cmp = 0;
    int n_fail = 0;
    int wv [9];
    int xv [9];
    int bv;

    conv_layer_seq_if #(.WIDTH(16), .N2(1), .K(9)) bus1 ();
    conv_layer_seq_if #(.WIDTH(16), .N2(4), .K(9)) bus4 ();

    conv_layer_seq #(.WIDTH(16), .FRAC(8), .N1(1), .N2(1), .FN(3)) dut1 (
        .clk        (clk),
        .resetn     (resetn),
        .cfg_clip   (clip1),
        .cfg_relu   (relu1),
        .cfg_relu_c (rc1),
        .bus        (bus1.slave),
        .busy       (busy1),
        .err        (err1)
    );

    conv_layer_seq #(.WIDTH(16), .FRAC(8), .N1(1), .N2(4), .FN(3)) dut4 (
        .clk        (clk),
        .resetn     (resetn),
        .cfg_clip   (clip4),
        .cfg_relu   (relu4),
        .cfg_relu_c (rc4),
        .bus        (bus4.slave),
        .busy       (busy4),
        .err        (err4)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the whole window.
    function automatic logic [15:0] ref_conv(input bit clip, input bit relu, input int rc);
        longint acc;
        longint r;
        logic [15:0] res;
        acc = longint'(bv) * 256;
        for (int i = 0; i < 9; i++)
            acc += longint'(xv[i]) * longint'(wv[i]);
        r = acc >>> 8;
        if (clip) begin
            if (r > 32767) r = 32767;
            if (r < -32768) r = -32768;
        end else begin
            r = ((r % 65536) + 65536) % 65536;
            if (r >= 32768) r -= 65536;
        end
        if (relu) begin
            if (r < 0) r = 0;
            if (rc != 0 && r > longint'(rc) * 256) r = longint'(rc) * 256;
        end
        res = r[15:0];
        return res;
    endfunction

    task automatic idle_all();
        bus1.in_valid = 0; bus1.in_data = '0; bus1.out_ready = 0;
        bus1.w_we = 0; bus1.w_addr = '0; bus1.w_data = '0;
        bus4.in_valid = 0; bus4.in_data = '0; bus4.out_ready = 0;
        bus4.w_we = 0; bus4.w_addr = '0; bus4.w_data = '0;
    endtask

    task automatic write1(input int a, input int d);
        bus1.w_we = 1; bus1.w_addr = 4'(a); bus1.w_data = 16'(d);
        @(negedge clk);
        bus1.w_we = 0;
    endtask

    task automatic write4(input int a, input int d);
        bus4.w_we = 1; bus4.w_addr = 6'(a); bus4.w_data = 16'(d);
        @(negedge clk);
        bus4.w_we = 0;
    endtask

    task automatic load1();
        for (int i = 0; i < 9; i++) write1(i, wv[i]);
        write1(9, bv);
    endtask

    task automatic fill(input int w, input int b, input int x);
        for (int i = 0; i < 9; i++) begin wv[i] = w; xv[i] = x; end
        bv = b;
    endtask

    task automatic send1(input int maxgap);
        for (int i = 0; i < 9; i++) begin
            int g;
            int t;
            g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            bus1.in_valid = 0;
            repeat (g) @(negedge clk);
            bus1.in_valid = 1; bus1.in_data = 16'(xv[i]);
            t = 0;
            while (!bus1.in_ready && t < 50) begin @(negedge clk); t++; end
            if (t >= 50) begin
                n_cmp++; n_fail++;
                $display("FAIL send1_ready_timeout sample %0d: in_ready stuck 0, required 1", i);
            end
            @(negedge clk);
        end
        bus1.in_valid = 0;
    endtask

    task automatic get1(input int hold, output logic [15:0] d, output logic l, output int lat);
        int n;
        n = 1;
        while (!bus1.out_valid && n < 200) begin @(negedge clk); n++; end
        lat = n;
        d = 'x; l = 1'bx;
        if (!bus1.out_valid) begin
            n_cmp++; n_fail++;
            $display("FAIL get1_timeout: out_valid 0 after %0d cycles, required 1", n);
        end else begin
            repeat (hold) @(negedge clk);
            d = bus1.out_data; l = bus1.out_last;
            bus1.out_ready = 1;
            @(negedge clk);
            bus1.out_ready = 0;
        end
    endtask

    task automatic do_reset();
        resetn = 0;
        idle_all();
        repeat (3) @(negedge clk);
        resetn = 1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        n_cmp++; if (bus1.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus1.in_ready); end
        n_cmp++; if (bus1.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus1.out_valid); end
        n_cmp++; if (bus1.out_data !== 16'd0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", bus1.out_data); end
        n_cmp++; if (bus1.out_last !== 1'b0 || bus1.out_ch !== 1'b0) begin n_fail++; $display("FAIL reset_ch_last got %b/%b want 0/0", bus1.out_ch, bus1.out_last); end
        n_cmp++; if (busy1 !== 1'b0 || err1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy_err got %b/%b want 0/0", busy1, err1); end
        n_cmp++; if (bus4.in_ready !== 1'b1 || bus4.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset4 got rdy %b vld %b want 1 0", bus4.in_ready, bus4.out_valid); end
    endtask

    task automatic test_basic();
        logic [15:0] d; logic l; int lat;
        clip1 = 1; relu1 = 0; rc1 = 0;
        fill(256, 0, 256);
        load1();
        send1(0);
        n_cmp++; if (busy1 !== 1'b1 || bus1.in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_busy got busy %b rdy %b want 1 0", busy1, bus1.in_ready); end
        get1(0, d, l, lat);
        n_cmp++; if (d !== 16'd2304) begin n_fail++; $display("FAIL basic_data got %0d want 2304", d); end
        n_cmp++; if (l !== 1'b1) begin n_fail++; $display("FAIL basic_last got %b want 1", l); end
        n_cmp++; if (lat !== 11) begin n_fail++; $display("FAIL basic_latency got %0d want 11", lat); end
    endtask

    task automatic test_clip();
        logic [15:0] d; logic l; int lat;
        fill(256, 0, 32512);
        load1();
        clip1 = 1; relu1 = 0; rc1 = 0;
        send1(0); get1(0, d, l, lat);
        n_cmp++; if (d !== 16'd32767) begin n_fail++; $display("FAIL clip_sat got %0d want 32767", d); end
        clip1 = 0;
        send1(0); get1(0, d, l, lat);
        n_cmp++; if (d !== 16'd30464) begin n_fail++; $display("FAIL clip_wrap got %0d want 30464", d); end
    endtask

    task automatic test_relu();
        logic [15:0] d; logic l; int lat;
        fill(256, -256, 0);
        load1();
        clip1 = 1; relu1 = 0; rc1 = 0;
        send1(0); get1(0, d, l, lat);
        n_cmp++; if (d !== 16'hFF00) begin n_fail++; $display("FAIL relu_off got %h want ff00", d); end
        relu1 = 1;
        send1(0); get1(0, d, l, lat);
        n_cmp++; if (d !== 16'h0000) begin n_fail++; $display("FAIL relu_neg got %h want 0000", d); end
        fill(256, 0, 256);
        load1();
        rc1 = 8'd6;
        send1(0); get1(0, d, l, lat);
        n_cmp++; if (d !== 16'd1536) begin n_fail++; $display("FAIL relu_clamp got %0d want 1536", d); end
        rc1 = 0; relu1 = 0;
    endtask

    task automatic test_channels();
        int n;
        clip4 = 1; relu4 = 0; rc4 = 0;
        for (int i = 0; i < 36; i++) write4(i, 0);
        for (int o = 0; o < 4; o++) write4(36 + o, o * 256);
        for (int i = 0; i < 9; i++) begin
            int t;
            bus4.in_valid = 1; bus4.in_data = '0;
            t = 0;
            while (!bus4.in_ready && t < 50) begin @(negedge clk); t++; end
            if (t >= 50) begin n_cmp++; n_fail++; $display("FAIL ch_send_timeout sample %0d", i); end
            @(negedge clk);
        end
        bus4.in_valid = 0;
        for (int ch = 0; ch < 4; ch++) begin
            n = 1;
            while (!bus4.out_valid && n < 200) begin @(negedge clk); n++; end
            n_cmp++; if (n !== 11) begin n_fail++; $display("FAIL ch_latency ch %0d got %0d want 11", ch, n); end
            for (int h = 0; h < 5; h++) begin
                n_cmp++;
                if (bus4.out_valid !== 1'b1 || bus4.out_data !== 16'(ch * 256) || bus4.out_ch !== 2'(ch)
                    || bus4.out_last !== (ch == 3) || bus4.in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ch_hold ch %0d cyc %0d got vld %b data %0d ch %0d last %b rdy %b want 1 %0d %0d %b 0",
                             ch, h, bus4.out_valid, bus4.out_data, bus4.out_ch, bus4.out_last, bus4.in_ready,
                             ch * 256, ch, (ch == 3));
                end
                @(negedge clk);
            end
            bus4.out_ready = 1;
            @(negedge clk);
            bus4.out_ready = 0;
        end
        n_cmp++; if (bus4.in_ready !== 1'b1 || busy4 !== 1'b0 || bus4.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL ch_done got rdy %b busy %b vld %b want 1 0 0", bus4.in_ready, busy4, bus4.out_valid);
        end
    endtask

    task automatic test_err_reset();
        logic [15:0] d; logic l; int lat;
        clip1 = 1; relu1 = 0; rc1 = 0;
        fill(256, 0, 256);
        load1();
        send1(0);
        write1(0, 16'h7FFF);
        n_cmp++; if (err1 !== 1'b1) begin n_fail++; $display("FAIL err_set got %b want 1", err1); end
        get1(0, d, l, lat);
        n_cmp++; if (d !== 16'd2304) begin n_fail++; $display("FAIL err_same_window got %0d want 2304", d); end
        send1(0); get1(0, d, l, lat);
        n_cmp++; if (d !== 16'd2304) begin n_fail++; $display("FAIL err_weight_kept got %0d want 2304", d); end
        n_cmp++; if (err1 !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b want 1", err1); end
        send1(0);
        repeat (3) @(negedge clk);
        resetn = 0;
        #1;
        n_cmp++; if (bus1.out_valid !== 1'b0 || bus1.in_ready !== 1'b1 || busy1 !== 1'b0 || err1 !== 1'b0) begin
            n_fail++; $display("FAIL midreset got vld %b rdy %b busy %b err %b want 0 1 0 0", bus1.out_valid, bus1.in_ready, busy1, err1);
        end
        @(negedge clk);
        resetn = 1;
        @(negedge clk);
        send1(0); get1(0, d, l, lat);
        n_cmp++; if (d !== 16'd2304 || lat !== 11) begin n_fail++; $display("FAIL midreset_fresh got %0d lat %0d want 2304 lat 11", d, lat); end
    endtask

    task automatic test_gaps();
        logic [15:0] d; logic l; int lat;
        clip1 = 1; relu1 = 0; rc1 = 0;
        fill(256, 0, 256);
        load1();
        send1(3); get1(0, d, l, lat);
        n_cmp++; if (d !== 16'd2304 || l !== 1'b1) begin n_fail++; $display("FAIL gaps got %0d last %b want 2304 1", d, l); end
    endtask

    task automatic test_random();
        logic [15:0] d; logic l; int lat; logic [15:0] exp_d;
        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < 9; i++) begin
                logic signed [15:0] a;
                logic signed [15:0] b;
                a = 16'($urandom); b = 16'($urandom);
                if (t < 5) begin a = a >>> 4; b = b >>> 4; end
                wv[i] = a; xv[i] = b;
            end
            begin
                logic signed [15:0] c;
                c = 16'($urandom);
                bv = c;
            end
            load1();
            clip1 = 1'($urandom); relu1 = 1'($urandom); rc1 = ($urandom_range(1, 0) == 1) ? 8'($urandom) : 8'd0;
            exp_d = ref_conv(clip1, relu1, int'(rc1));
            send1(int'($urandom_range(2, 0)));
            get1(int'($urandom_range(2, 0)), d, l, lat);
            n_cmp++; if (d !== exp_d) begin n_fail++; $display("FAIL random_%0d data got %h want %h (clip %b relu %b rc %0d)", t, d, exp_d, clip1, relu1, rc1); end
            n_cmp++; if (lat !== 11) begin n_fail++; $display("FAIL random_%0d latency got %0d want 11", t, lat); end
        end
    endtask

    initial begin
        clip1 = 0; relu1 = 0; rc1 = 0;
        clip4 = 0; relu4 = 0; rc4 = 0;
        do_reset();
        test_reset();
        test_basic();
        test_clip();
        test_relu();
        test_channels();
        test_err_reset();
        test_gaps();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
